// File: rtl/dense_layer_tm_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed dense layer.
package dense_layer_tm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_BIAS,
    ST_DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Wide enough that IN_SIZE signed products never overflow.
  function automatic int acc_width(input int w, input int wi, input int in_size);
    return w + wi + $clog2(in_size) + 1;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_layer_tm_mac_lane.sv
// One shared multiply-accumulate lane; clr has priority over en.
module mac_lane #(
  parameter int WIDTH    = 8,
  parameter int WIDTH_IN = 8,
  parameter int ACC_W    = 19
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [WIDTH_IN-1:0] x,
  input  logic signed [WIDTH-1:0]    w,
  output logic signed [ACC_W-1:0]    acc
);

  // Operands are widened before the multiply so the product is not truncated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(x) * ACC_W'(w);
    end
  end

endmodule

// File: rtl/dense_layer_tm.sv
// Time-multiplexed dense layer: PAR shared MAC lanes sweep the neurons in groups,
// then a bias/ReLU/saturate stage writes each neuron's registered activation.
module dense_layer_tm
  import dense_layer_tm_pkg::*;
#(
  parameter int NEURON_NB = 32,
  parameter int IN_SIZE   = 196,
  parameter int WIDTH     = 8,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 32,
  parameter int PAR       = 4,
  parameter int RELU      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dense_go,
  input  logic [WIDTH_IN*IN_SIZE-1:0]       dense_in,
  input  logic [WIDTH*NEURON_NB*IN_SIZE-1:0] weights,
  input  logic [WIDTH*NEURON_NB-1:0]        biases,
  output logic [WIDTH_OUT*NEURON_NB-1:0]    dense_out,
  output logic                              dense_busy,
  output logic                              dense_done
);

  localparam int GROUPS = ceil_div(NEURON_NB, PAR);
  localparam int ACC_W  = acc_width(WIDTH, WIDTH_IN, IN_SIZE);
  localparam int NIW    = idx_width(NEURON_NB);
  localparam int KW     = idx_width(IN_SIZE);
  localparam int GW     = idx_width(GROUPS);
  localparam int S_W    = ((ACC_W > WIDTH) ? ACC_W : WIDTH) + 1;
  localparam int EXT    = ((S_W > WIDTH_OUT) ? S_W : WIDTH_OUT) + 1;

  localparam logic signed [EXT-1:0] ONE     = 1;
  localparam logic signed [EXT-1:0] SAT_MAX = (ONE <<< (WIDTH_OUT - 1)) - ONE;
  localparam logic signed [EXT-1:0] SAT_MIN = -(ONE <<< (WIDTH_OUT - 1));

  state_t           state;
  logic [KW-1:0]    k;
  logic [GW-1:0]    g;
  logic             go_acc;
  logic             lane_clr;
  logic             lane_en;
  logic signed [WIDTH_IN-1:0] x_k;

  logic signed [WIDTH_IN-1:0]  x_arr [IN_SIZE];
  logic signed [WIDTH-1:0]     w_arr [NEURON_NB][IN_SIZE];
  logic signed [WIDTH-1:0]     b_arr [NEURON_NB];
  logic signed [WIDTH_OUT-1:0] out_r [NEURON_NB];

  logic signed [WIDTH_OUT-1:0] lane_res [PAR];
  logic [NIW-1:0]              lane_idx [PAR];
  logic                        lane_ok  [PAR];

  for (genvar i = 0; i < IN_SIZE; i++) begin : g_x
    assign x_arr[i] = dense_in[i*WIDTH_IN +: WIDTH_IN];
  end

  for (genvar n = 0; n < NEURON_NB; n++) begin : g_n
    assign b_arr[n] = biases[n*WIDTH +: WIDTH];
    assign dense_out[n*WIDTH_OUT +: WIDTH_OUT] = out_r[n];
    for (genvar i = 0; i < IN_SIZE; i++) begin : g_w
      assign w_arr[n][i] = weights[(n*IN_SIZE + i)*WIDTH +: WIDTH];
    end
  end

  // Start is honoured only when idle or finished; accumulators clear on start and after each bias write.
  always_comb begin
    go_acc   = dense_go && (state == ST_IDLE || state == ST_DONE);
    lane_clr = go_acc || (state == ST_BIAS);
    lane_en  = (state == ST_MAC);
    x_k      = x_arr[k];
  end

  for (genvar j = 0; j < PAR; j++) begin : g_lane
    int unsigned                 nf;
    logic                        n_ok;
    logic [NIW-1:0]              n_idx;
    logic signed [WIDTH-1:0]     w_sel;
    logic signed [WIDTH-1:0]     b_sel;
    logic signed [ACC_W-1:0]     acc;
    logic signed [EXT-1:0]       s;

    // Lanes past the last neuron point at slot 0 so no slice goes out of range; their write is masked.
    always_comb begin
      nf    = int'(g) * PAR + j;
      n_ok  = (nf < NEURON_NB);
      n_idx = n_ok ? NIW'(nf) : '0;
      w_sel = w_arr[n_idx][k];
      b_sel = b_arr[n_idx];
      s     = EXT'(acc) + EXT'(b_sel);
      if (RELU != 0 && s < 0) s = '0;
      if (s > SAT_MAX) s = SAT_MAX;
      else if (s < SAT_MIN) s = SAT_MIN;
      lane_res[j] = s[WIDTH_OUT-1:0];
      lane_idx[j] = n_idx;
      lane_ok[j]  = n_ok;
    end

    mac_lane #(
      .WIDTH    (WIDTH),
      .WIDTH_IN (WIDTH_IN),
      .ACC_W    (ACC_W)
    ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (lane_clr),
      .en    (lane_en),
      .x     (x_k),
      .w     (w_sel),
      .acc   (acc)
    );
  end

  // Control FSM with g/k counters, registered busy/done and the output register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      k          <= '0;
      g          <= '0;
      dense_busy <= 1'b0;
      dense_done <= 1'b0;
      for (int unsigned n = 0; n < NEURON_NB; n++) out_r[n] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go_acc) begin
            state      <= ST_MAC;
            k          <= '0;
            g          <= '0;
            dense_busy <= 1'b1;
            dense_done <= 1'b0;
          end
        end
        ST_MAC: begin
          if (k == KW'(IN_SIZE - 1)) state <= ST_BIAS;
          else k <= k + KW'(1);
        end
        ST_BIAS: begin
          for (int unsigned j = 0; j < PAR; j++) begin
            if (lane_ok[j]) out_r[lane_idx[j]] <= lane_res[j];
          end
          k <= '0;
          if (g == GW'(GROUPS - 1)) begin
            state      <= ST_DONE;
            dense_busy <= 1'b0;
            dense_done <= 1'b1;
          end else begin
            g     <= g + GW'(1);
            state <= ST_MAC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_tm.sv
// Directed bench: four dense_layer_tm instances (ReLU, linear, 8-bit saturating, PAR=5)
// sharing the same operands; expected activations are hand-computed constants.
module tb_dense_layer_tm;

  localparam int NN = 5;
  localparam int IS = 3;

  logic clk = 1'b0;
  logic reset;
  logic go;
  logic go_d;
  logic [8*IS-1:0]    din;
  logic [8*NN*IS-1:0] wts;
  logic [8*NN-1:0]    bias;

  logic [32*NN-1:0] a_out, b_out, d_out;
  logic [8*NN-1:0]  c_out;
  logic a_busy, a_done, b_busy, b_done, c_busy, c_done, d_busy, d_done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dense_layer_tm #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(8), .WIDTH_IN(8),
                   .WIDTH_OUT(32), .PAR(2), .RELU(1)) u_a (
    .clk(clk), .reset(reset), .dense_go(go), .dense_in(din), .weights(wts),
    .biases(bias), .dense_out(a_out), .dense_busy(a_busy), .dense_done(a_done));

  dense_layer_tm #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(8), .WIDTH_IN(8),
                   .WIDTH_OUT(32), .PAR(2), .RELU(0)) u_b (
    .clk(clk), .reset(reset), .dense_go(go), .dense_in(din), .weights(wts),
    .biases(bias), .dense_out(b_out), .dense_busy(b_busy), .dense_done(b_done));

  dense_layer_tm #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(8), .WIDTH_IN(8),
                   .WIDTH_OUT(8), .PAR(2), .RELU(0)) u_c (
    .clk(clk), .reset(reset), .dense_go(go), .dense_in(din), .weights(wts),
    .biases(bias), .dense_out(c_out), .dense_busy(c_busy), .dense_done(c_done));

  dense_layer_tm #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(8), .WIDTH_IN(8),
                   .WIDTH_OUT(32), .PAR(5), .RELU(1)) u_d (
    .clk(clk), .reset(reset), .dense_go(go_d), .dense_in(din), .weights(wts),
    .biases(bias), .dense_out(d_out), .dense_busy(d_busy), .dense_done(d_done));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 1: x=1 w=1 b=n; 2: x=2 w=-1 b=1; 3: x=w=b=127; 4: x=127 w=-128 b=127; 5: x=k+1 w=n-2 b=n
  task automatic load(input int mode);
    for (int n = 0; n < NN; n++) begin
      case (mode)
        1: bias[n*8 +: 8] = 8'(n);
        2: bias[n*8 +: 8] = 8'(1);
        3, 4: bias[n*8 +: 8] = 8'(127);
        default: bias[n*8 +: 8] = 8'(n);
      endcase
      for (int i = 0; i < IS; i++) begin
        case (mode)
          1: begin din[i*8 +: 8] = 8'(1);   wts[(n*IS+i)*8 +: 8] = 8'(1);    end
          2: begin din[i*8 +: 8] = 8'(2);   wts[(n*IS+i)*8 +: 8] = 8'(-1);   end
          3: begin din[i*8 +: 8] = 8'(127); wts[(n*IS+i)*8 +: 8] = 8'(127);  end
          4: begin din[i*8 +: 8] = 8'(127); wts[(n*IS+i)*8 +: 8] = 8'(-128); end
          default: begin din[i*8 +: 8] = 8'(i+1); wts[(n*IS+i)*8 +: 8] = 8'(n-2); end
        endcase
      end
    end
  endtask

  task automatic start(input bit use_d);
    @(negedge clk);
    if (use_d) go_d = 1'b1; else go = 1'b1;
    @(negedge clk);
    go   = 1'b0;
    go_d = 1'b0;
    chk("busy_after_go", use_d ? d_busy : a_busy, 1);
    chk("done_after_go", use_d ? d_done : a_done, 0);
  endtask

  // Counts edges after the accepting edge until done; optionally pulses go while busy.
  task automatic wait_done(input bit use_d, input int p0, input int p1,
                           output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = (use_d ? d_busy : a_busy) ? 1 : 0;
    while (!(use_d ? d_done : a_done) && cyc < 100) begin
      if (!use_d) go = (cyc >= p0 && cyc <= p1);
      @(negedge clk);
      cyc++;
      if (use_d ? d_busy : a_busy) bcnt++;
    end
    go = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input int ea[NN], input int eb[NN], input int ec[NN]);
    for (int n = 0; n < NN; n++) begin
      chk({tag, "_relu"}, $signed(a_out[n*32 +: 32]), ea[n]);
      chk({tag, "_lin"},  $signed(b_out[n*32 +: 32]), eb[n]);
      chk({tag, "_sat8"}, $signed(c_out[n*8 +: 8]),   ec[n]);
    end
  endtask

  int cyc, bcnt;
  int e1[NN]   = '{3, 4, 5, 6, 7};
  int z[NN]    = '{0, 0, 0, 0, 0};
  int m5[NN]   = '{-5, -5, -5, -5, -5};
  int p48[NN]  = '{48514, 48514, 48514, 48514, 48514};
  int s127[NN] = '{127, 127, 127, 127, 127};
  int n48[NN]  = '{-48641, -48641, -48641, -48641, -48641};
  int s128[NN] = '{-128, -128, -128, -128, -128};
  int r5[NN]   = '{0, 0, 2, 9, 16};
  int l5[NN]   = '{-12, -5, 2, 9, 16};

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    go_d  = 1'b0;
    load(1);
    repeat (3) @(negedge clk);
    chk("rst_out_a", a_out, 0);
    chk("rst_out_d", d_out, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_done",  a_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic run, latency and busy duration
    start(0);
    wait_done(0, -1, -1, cyc, bcnt);
    chk("t1_latency", cyc, 12);
    chk("t1_busy_cycles", bcnt, 12);
    chk("t1_busy_low", a_busy, 0);
    chk_outs("t1", e1, e1, e1);

    // Negative sums: ReLU vs linear
    load(2);
    start(0);
    wait_done(0, -1, -1, cyc, bcnt);
    chk("t2_latency", cyc, 12);
    chk_outs("t2", z, m5, m5);

    // Saturation at both ends of an 8-bit output
    load(3);
    start(0);
    wait_done(0, -1, -1, cyc, bcnt);
    chk_outs("t3p", p48, p48, s127);
    load(4);
    start(0);
    wait_done(0, -1, -1, cyc, bcnt);
    chk_outs("t3n", z, n48, s128);

    // go while in BIAS/MAC is ignored; per-neuron distinct values
    load(5);
    start(0);
    wait_done(0, 3, 4, cyc, bcnt);
    chk("t4_latency_ignored_go", cyc, 12);
    chk_outs("t4", r5, l5, l5);

    // go in DONE: done drops, old slots retained until rewritten
    load(1);
    start(0);
    chk("t4_slot4_kept", $signed(a_out[4*32 +: 32]), 16);
    wait_done(0, -1, -1, cyc, bcnt);
    chk("t4_relaunch_latency", cyc, 12);
    chk_outs("t4b", e1, e1, e1);

    // Reset mid-run
    load(5);
    start(0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_out_cleared", a_out, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_done", a_done, 0);
    @(negedge clk);
    reset = 1'b0;
    load(1);
    start(0);
    wait_done(0, -1, -1, cyc, bcnt);
    chk("t5_latency", cyc, 12);
    chk_outs("t5", e1, e1, e1);

    // Masked lane leaves no unknowns; single-group configuration
    chk("t6_no_x", $isunknown(a_out), 0);
    start(1);
    wait_done(1, -1, -1, cyc, bcnt);
    chk("t6_par5_latency", cyc, 4);
    chk("t6_par5_busy", bcnt, 4);
    for (int n = 0; n < NN; n++) chk("t6_par5_out", $signed(d_out[n*32 +: 32]), e1[n]);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
